sublime_stereo_mixer: RTL

Next-generation voice mixer for the Sublime synth. It takes the time-multiplexed per-voice sample stream from the voice engine and scales each sample by an unsigned velocity and a per-voice pan position. Left and right sums are accumulated in a guard-banded accumulator, saturated to DATA_WIDTH, and emitted once per frame with a valid strobe and clip flags. It sits between the voice engine/filter output and the DAC/I2S serialiser.

---
 rtl/sublime_mixer_pkg.sv | 39 +++
 rtl/sublime_pan_scaler.sv | 60 ++++++
 rtl/sublime_stereo_mixer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sublime_mixer_pkg.sv
// Shared widths, result types and arithmetic helpers for the Sublime stereo mixer.
// Helpers work on wide vectors so any DATA_WIDTH/PAN_WIDTH below 32 can use them.
package sublime_mixer_pkg;

  typedef struct packed {
    logic        clip;
    logic [63:0] value;
  } sat_res_t;

  function automatic int acc_width(input int data_w, input int voices);
    return data_w + $clog2(voices) + 1;
  endfunction

  // Clamp a sign-extended accumulator to a data_w-bit signed range and flag the clamp.
  function automatic sat_res_t saturate(input logic signed [63:0] x, input int data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           res;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) begin
      res.clip  = 1'b1;
      res.value = hi;
    end else if (x < lo) begin
      res.clip  = 1'b1;
      res.value = lo;
    end else begin
      res.clip  = 1'b0;
      res.value = x;
    end
    return res;
  endfunction

  // Low PAN_WIDTH bits of the result equal (2^PAN_WIDTH-1) - pan.
  function automatic logic [31:0] pan_complement(input logic [31:0] pan);
    return ~pan;
  endfunction

endpackage

// File: rtl/sublime_pan_scaler.sv
// Registered pan stage: splits a velocity-scaled sample into left/right gains.
// Voice index and valid travel alongside so the accumulator sees aligned data.
module sublime_pan_scaler
  import sublime_mixer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PAN_WIDTH  = 8,
  parameter int VW         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [VW-1:0]         in_voice,
  input  logic [DATA_WIDTH-1:0] in_v,
  input  logic [PAN_WIDTH-1:0]  in_pan,
  output logic                  out_valid,
  output logic [VW-1:0]         out_voice,
  output logic [DATA_WIDTH-1:0] out_l,
  output logic [DATA_WIDTH-1:0] out_r
);

  localparam int PROD_W = DATA_WIDTH + PAN_WIDTH + 1;

  logic [31:0]              comp_full_s;
  logic signed [PROD_W-1:0] v_ext_s;
  logic signed [PROD_W-1:0] gain_l_s;
  logic signed [PROD_W-1:0] gain_r_s;
  logic signed [PROD_W-1:0] prod_l_s;
  logic signed [PROD_W-1:0] prod_r_s;
  logic                     unused_s;

  // Full-precision signed x unsigned products; gains are zero-extended.
  always_comb begin
    comp_full_s = pan_complement({{(32-PAN_WIDTH){1'b0}}, in_pan});
    v_ext_s     = {{(PAN_WIDTH+1){in_v[DATA_WIDTH-1]}}, in_v};
    gain_l_s    = {{(DATA_WIDTH+1){1'b0}}, comp_full_s[PAN_WIDTH-1:0]};
    gain_r_s    = {{(DATA_WIDTH+1){1'b0}}, in_pan};
    prod_l_s    = v_ext_s * gain_l_s;
    prod_r_s    = v_ext_s * gain_r_s;
  end

  assign unused_s = ^{comp_full_s[31:PAN_WIDTH], prod_l_s[PAN_WIDTH-1:0], prod_l_s[PROD_W-1],
                      prod_r_s[PAN_WIDTH-1:0], prod_r_s[PROD_W-1]};

  // Slicing above the pan bits is the floor shift by PAN_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_voice <= {VW{1'b0}};
      out_l     <= {DATA_WIDTH{1'b0}};
      out_r     <= {DATA_WIDTH{1'b0}};
    end else begin
      out_valid <= in_valid;
      out_voice <= in_voice;
      out_l     <= prod_l_s[PAN_WIDTH +: DATA_WIDTH];
      out_r     <= prod_r_s[PAN_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/sublime_stereo_mixer.sv
// Stereo voice mixer: velocity scale, pan split, guard-banded accumulate, saturate.
// Voice 0 delimits frames; each voice-0 emits the previous frame once primed.
module sublime_stereo_mixer
  import sublime_mixer_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int DATA_WIDTH = 32,
  parameter int VEL_WIDTH  = 8,
  parameter int PAN_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [$clog2(NUM_VOICES)-1:0] in_voice,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [VEL_WIDTH-1:0]          in_velocity,
  input  logic [PAN_WIDTH-1:0]          in_pan,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_left,
  output logic [DATA_WIDTH-1:0]         out_right,
  output logic                          clip_l,
  output logic                          clip_r
);

  localparam int VW     = $clog2(NUM_VOICES);
  localparam int ACC_W  = acc_width(DATA_WIDTH, NUM_VOICES);
  localparam int PROD_W = DATA_WIDTH + VEL_WIDTH + 1;

  logic signed [PROD_W-1:0] data_ext_s;
  logic signed [PROD_W-1:0] vel_ext_s;
  logic signed [PROD_W-1:0] vel_prod_s;

  logic                  s1_valid_r;
  logic [VW-1:0]         s1_voice_r;
  logic [DATA_WIDTH-1:0] s1_v_r;
  logic [PAN_WIDTH-1:0]  s1_pan_r;

  logic                  s2_valid_s;
  logic [VW-1:0]         s2_voice_s;
  logic [DATA_WIDTH-1:0] s2_l_s;
  logic [DATA_WIDTH-1:0] s2_r_s;

  logic [ACC_W-1:0] acc_l_r;
  logic [ACC_W-1:0] acc_r_r;
  logic [ACC_W-1:0] l_ext_s;
  logic [ACC_W-1:0] r_ext_s;
  logic             primed_r;
  sat_res_t         sat_l_s;
  sat_res_t         sat_r_s;
  logic             unused_s;

  // Velocity product: signed sample times zero-extended velocity.
  always_comb begin
    data_ext_s = {{(VEL_WIDTH+1){in_data[DATA_WIDTH-1]}}, in_data};
    vel_ext_s  = {{(DATA_WIDTH+1){1'b0}}, in_velocity};
    vel_prod_s = data_ext_s * vel_ext_s;
  end

  // S1 register; the slice is the floor shift by VEL_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_voice_r <= {VW{1'b0}};
      s1_v_r     <= {DATA_WIDTH{1'b0}};
      s1_pan_r   <= {PAN_WIDTH{1'b0}};
    end else begin
      s1_valid_r <= in_valid;
      s1_voice_r <= in_voice;
      s1_v_r     <= vel_prod_s[VEL_WIDTH +: DATA_WIDTH];
      s1_pan_r   <= in_pan;
    end
  end

  sublime_pan_scaler #(
    .DATA_WIDTH (DATA_WIDTH),
    .PAN_WIDTH  (PAN_WIDTH),
    .VW         (VW)
  ) u_pan_scaler (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid_r),
    .in_voice  (s1_voice_r),
    .in_v      (s1_v_r),
    .in_pan    (s1_pan_r),
    .out_valid (s2_valid_s),
    .out_voice (s2_voice_s),
    .out_l     (s2_l_s),
    .out_r     (s2_r_s)
  );

  // Sign-extend the stage-2 terms and saturate the running sums.
  always_comb begin
    l_ext_s = {{(ACC_W-DATA_WIDTH){s2_l_s[DATA_WIDTH-1]}}, s2_l_s};
    r_ext_s = {{(ACC_W-DATA_WIDTH){s2_r_s[DATA_WIDTH-1]}}, s2_r_s};
    sat_l_s = saturate({{(64-ACC_W){acc_l_r[ACC_W-1]}}, acc_l_r}, DATA_WIDTH);
    sat_r_s = saturate({{(64-ACC_W){acc_r_r[ACC_W-1]}}, acc_r_r}, DATA_WIDTH);
  end

  assign unused_s = ^{vel_prod_s[VEL_WIDTH-1:0], vel_prod_s[PROD_W-1],
                      sat_l_s.value[63:DATA_WIDTH], sat_r_s.value[63:DATA_WIDTH]};

  // Accumulate; a voice-0 closes the previous frame (once primed) and seeds the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l_r   <= {ACC_W{1'b0}};
      acc_r_r   <= {ACC_W{1'b0}};
      primed_r  <= 1'b0;
      out_valid <= 1'b0;
      out_left  <= {DATA_WIDTH{1'b0}};
      out_right <= {DATA_WIDTH{1'b0}};
      clip_l    <= 1'b0;
      clip_r    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (s2_valid_s) begin
        if (s2_voice_s != {VW{1'b0}}) begin
          acc_l_r <= acc_l_r + l_ext_s;
          acc_r_r <= acc_r_r + r_ext_s;
        end else begin
          if (primed_r) begin
            out_valid <= 1'b1;
            out_left  <= sat_l_s.value[DATA_WIDTH-1:0];
            out_right <= sat_r_s.value[DATA_WIDTH-1:0];
            clip_l    <= sat_l_s.clip;
            clip_r    <= sat_r_s.clip;
          end else begin
            primed_r <= 1'b1;
          end
          acc_l_r <= l_ext_s;
          acc_r_r <= r_ext_s;
        end
      end else begin
        acc_l_r <= acc_l_r;
        acc_r_r <= acc_r_r;
      end
    end
  end

endmodule
